// File: rtl/i2c_pin_arbiter.sv
// i2c_pin_arbiter: shares one I2C pad pair among NUM_MST controllers.
// Pads are handed over only when the bus is observed free (or the wait
// times out), with a release interval in between so pad drive never jumps
// straight from one master to another.
module i2c_pin_arbiter #(
    parameter int                 NUM_MST  = 2,
    parameter logic [NUM_MST-1:0] DIR_INV  = '0,
    parameter int                 RST_SEL  = 0,
    parameter int                 IDLE_CYC = 16,
    parameter int                 PARK_CYC = 2,
    parameter int                 TMO_CYC  = 4096,
    localparam int                SW       = $clog2(NUM_MST)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sel_valid_i,
    input  logic [SW-1:0]      sel_id_i,
    output logic               sel_ready_o,
    output logic [SW-1:0]      sel_cur_o,
    output logic               done_o,
    output logic               tmo_o,
    output logic               err_o,
    output logic               busy_o,
    input  logic [NUM_MST-1:0] mst_scl_o_i,
    input  logic [NUM_MST-1:0] mst_scl_dir_i,
    input  logic [NUM_MST-1:0] mst_sda_o_i,
    input  logic [NUM_MST-1:0] mst_sda_dir_i,
    output logic [NUM_MST-1:0] mst_scl_i_o,
    output logic [NUM_MST-1:0] mst_sda_i_o,
    input  logic               pad_scl_i,
    input  logic               pad_sda_i,
    output logic               pad_scl_o,
    output logic               pad_scl_dir_o,
    output logic               pad_sda_o,
    output logic               pad_sda_dir_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PARK} state_t;

    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int PW = 4;
    localparam int IW = 8;

    logic [1:0]    r_scl_sync, r_sda_sync;
    logic          r_scl_d, r_sda_d;
    logic          w_scl_s, w_sda_s;
    logic          w_start, w_stop, w_bus_free;
    logic          r_busy;
    logic [IW-1:0] r_idle_cnt;

    state_t        r_state, w_state;
    logic [SW-1:0] r_cur, w_cur, r_tgt, w_tgt;
    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt;
    logic [PW-1:0] r_park_cnt, w_park_cnt;
    logic          r_tmo_flag, w_tmo_flag;
    logic          r_done, w_done, r_tmo, w_tmo, r_err, w_err;
    logic          w_id_bad, w_park;

    logic [NUM_MST-1:0] w_scl_dir_n, w_sda_dir_n;
    logic          w_scl_o_cur, w_scl_dir_cur, w_sda_o_cur, w_sda_dir_cur;

    assign w_scl_s = r_scl_sync[1];
    assign w_sda_s = r_sda_sync[1];

    // Two-flop synchronisers plus one delayed copy for edge detection; idle-high reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], pad_scl_i};
            r_sda_sync <= {r_sda_sync[0], pad_sda_i};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    // SDA edges while SCL stays high mark START / STOP
    assign w_start    = r_sda_d & ~w_sda_s & w_scl_s & r_scl_d;
    assign w_stop     = ~r_sda_d & w_sda_s & w_scl_s & r_scl_d;
    assign w_bus_free = (r_idle_cnt == IW'(IDLE_CYC));

    // Bus monitor: busy flag (STOP wins) and saturating idle-line counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy     <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            if (w_stop)       r_busy <= 1'b0;
            else if (w_start) r_busy <= 1'b1;
            if (!r_busy && w_scl_s && w_sda_s) begin
                if (!w_bus_free) r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign w_id_bad = (int'(sel_id_i) >= NUM_MST);

    // FSM state and datapath registers; reset drops any pending switch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cur      <= SW'(RST_SEL);
            r_tgt      <= SW'(RST_SEL);
            r_tmo_cnt  <= '0;
            r_park_cnt <= '0;
            r_tmo_flag <= 1'b0;
            r_done     <= 1'b0;
            r_tmo      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cur      <= w_cur;
            r_tgt      <= w_tgt;
            r_tmo_cnt  <= w_tmo_cnt;
            r_park_cnt <= w_park_cnt;
            r_tmo_flag <= w_tmo_flag;
            r_done     <= w_done;
            r_tmo      <= w_tmo;
            r_err      <= w_err;
        end
    end

    // Next-state: accept in IDLE, wait for free bus or timeout, then park
    always_comb begin
        w_state    = r_state;
        w_cur      = r_cur;
        w_tgt      = r_tgt;
        w_tmo_cnt  = r_tmo_cnt;
        w_park_cnt = r_park_cnt;
        w_tmo_flag = r_tmo_flag;
        w_done     = 1'b0;
        w_tmo      = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sel_valid_i) begin
                    if (w_id_bad) begin
                        w_err = 1'b1;
                    end else if (sel_id_i == r_cur) begin
                        w_done = 1'b1;
                    end else begin
                        w_tgt      = sel_id_i;
                        w_tmo_cnt  = '0;
                        w_tmo_flag = 1'b0;
                        w_state    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_bus_free) begin
                    w_park_cnt = '0;
                    w_state    = S_PARK;
                end else if (TMO_CYC != 0 && r_tmo_cnt == TW'(TMO_CYC - 1)) begin
                    w_tmo_flag = 1'b1;
                    w_park_cnt = '0;
                    w_state    = S_PARK;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + 1'b1;
                end
            end
            S_PARK: begin
                if (r_park_cnt == PW'(PARK_CYC - 1)) begin
                    w_cur   = r_tgt;
                    w_done  = 1'b1;
                    w_tmo   = r_tmo_flag;
                    w_state = S_IDLE;
                end else begin
                    w_park_cnt = r_park_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign sel_ready_o = (r_state == S_IDLE);
    assign sel_cur_o   = r_cur;
    assign done_o      = r_done;
    assign tmo_o       = r_tmo;
    assign err_o       = r_err;
    assign busy_o      = r_busy;
    assign w_park      = (r_state == S_PARK);

    assign w_scl_dir_n = mst_scl_dir_i ^ DIR_INV;
    assign w_sda_dir_n = mst_sda_dir_i ^ DIR_INV;

    // Pick the connected master's drive; loop compare keeps unused id codes harmless
    always_comb begin
        w_scl_o_cur   = 1'b1;
        w_scl_dir_cur = 1'b0;
        w_sda_o_cur   = 1'b1;
        w_sda_dir_cur = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (r_cur == SW'(k)) begin
                w_scl_o_cur   = mst_scl_o_i[k];
                w_scl_dir_cur = w_scl_dir_n[k];
                w_sda_o_cur   = mst_sda_o_i[k];
                w_sda_dir_cur = w_sda_dir_n[k];
            end
        end
    end

    assign pad_scl_o     = w_park ? 1'b1 : w_scl_o_cur;
    assign pad_scl_dir_o = w_park ? 1'b0 : w_scl_dir_cur;
    assign pad_sda_o     = w_park ? 1'b1 : w_sda_o_cur;
    assign pad_sda_dir_o = w_park ? 1'b0 : w_sda_dir_cur;

    // Unselected masters, and everyone while parked, see an idle bus
    for (genvar k = 0; k < NUM_MST; k++) begin : g_mst_in
        assign mst_scl_i_o[k] = (!w_park && r_cur == SW'(k)) ? w_scl_s : 1'b1;
        assign mst_sda_i_o[k] = (!w_park && r_cur == SW'(k)) ? w_sda_s : 1'b1;
    end

endmodule

// File: tb/tb_i2c_pin_arbiter.sv
// tb_i2c_pin_arbiter: directed scenarios plus random traffic, checked every
// cycle against an event-scheduled reference model of the arbiter.
module tb_i2c_pin_arbiter;
    localparam int NM = 3, IDLE = 16, PARK = 2, TMO = 64, RSEL = 1;
    localparam logic [2:0] DINV = 3'b010;

    logic       clk_i = 1'b0, rst_i = 1'b0;
    logic       sel_valid_i = 1'b0;
    logic [1:0] sel_id_i = '0;
    logic [1:0] sel_cur_o;
    logic       sel_ready_o, done_o, tmo_o, err_o, busy_o;
    logic [2:0] mst_scl_o_i = '0, mst_scl_dir_i = '0, mst_sda_o_i = '0, mst_sda_dir_i = '0;
    logic [2:0] mst_scl_i_o, mst_sda_i_o;
    logic       pad_scl_i = 1'b1, pad_sda_i = 1'b1;
    logic       pad_scl_o, pad_scl_dir_o, pad_sda_o, pad_sda_dir_o;

    always #5 clk_i = ~clk_i;

    i2c_pin_arbiter #(.NUM_MST(NM), .DIR_INV(DINV), .RST_SEL(RSEL), .IDLE_CYC(IDLE),
                      .PARK_CYC(PARK), .TMO_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sel_valid_i(sel_valid_i), .sel_id_i(sel_id_i),
        .sel_ready_o(sel_ready_o), .sel_cur_o(sel_cur_o), .done_o(done_o), .tmo_o(tmo_o),
        .err_o(err_o), .busy_o(busy_o), .mst_scl_o_i(mst_scl_o_i), .mst_scl_dir_i(mst_scl_dir_i),
        .mst_sda_o_i(mst_sda_o_i), .mst_sda_dir_i(mst_sda_dir_i), .mst_scl_i_o(mst_scl_i_o),
        .mst_sda_i_o(mst_sda_i_o), .pad_scl_i(pad_scl_i), .pad_sda_i(pad_sda_i),
        .pad_scl_o(pad_scl_o), .pad_scl_dir_o(pad_scl_dir_o), .pad_sda_o(pad_sda_o),
        .pad_sda_dir_o(pad_sda_dir_o));

    int n_cmp = 0, n_err = 0;
    int t;

    // reference model state: pad history, bus events, scheduled switch times
    bit hs[$], hd[$];
    bit ps_scl, ps_sda, m_busy, m_sw, m_flag;
    int m_lastbad, m_cur, m_acc, m_ps, m_dc, m_tgt;
    int m_done_at, m_tmo_at, m_err_at;
    int last_done_t, last_tmo_t, last_err_t;
    logic [2:0] dinv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        hs.delete(); hd.delete();
        ps_scl = 1; ps_sda = 1; m_busy = 0; m_lastbad = -1;
        m_cur = RSEL; m_sw = 0; m_flag = 0; m_acc = -1; m_ps = -1; m_dc = -1; m_tgt = RSEL;
        m_done_at = -1; m_tmo_at = -1; m_err_at = -1;
        last_done_t = -1; last_tmo_t = -1; last_err_t = -1;
    endtask

    // One clock cycle: drive inputs at the negedge, check #1 later, advance the model
    task automatic cycle(input bit v, input int id, input bit scl, input bit sda);
        int mode;
        bit s_scl, s_sda, st, sp, free_now;
        logic [3:0] e_pad;
        logic [2:0] e_si, e_di;
        if (m_sw && m_ps >= 0 && t == m_dc) begin m_cur = m_tgt; m_sw = 0; end
        mode = 0;
        if (m_sw && t > m_acc) mode = (m_ps >= 0 && t >= m_ps) ? 2 : 1;
        sel_valid_i = v; sel_id_i = 2'(id); pad_scl_i = scl; pad_sda_i = sda;
        mst_scl_o_i = 3'($urandom); mst_scl_dir_i = 3'($urandom);
        mst_sda_o_i = 3'($urandom); mst_sda_dir_i = 3'($urandom);
        hs.push_back(scl); hd.push_back(sda);
        s_scl = (t >= 2) ? hs[t-2] : 1'b1;
        s_sda = (t >= 2) ? hd[t-2] : 1'b1;
        #1;
        if (mode == 2) e_pad = 4'b1010;
        else e_pad = {mst_scl_o_i[m_cur], mst_scl_dir_i[m_cur] ^ dinv[m_cur],
                      mst_sda_o_i[m_cur], mst_sda_dir_i[m_cur] ^ dinv[m_cur]};
        for (int k = 0; k < NM; k++) begin
            e_si[k] = (mode != 2 && k == m_cur) ? s_scl : 1'b1;
            e_di[k] = (mode != 2 && k == m_cur) ? s_sda : 1'b1;
        end
        chk("ready", sel_ready_o, mode == 0);
        chk("cur", sel_cur_o, m_cur);
        chk("done", done_o, t == m_done_at);
        chk("tmo", tmo_o, t == m_tmo_at);
        chk("err", err_o, t == m_err_at);
        chk("busy", busy_o, m_busy);
        chk("pads", {pad_scl_o, pad_scl_dir_o, pad_sda_o, pad_sda_dir_o}, e_pad);
        chk("mst_scl_in", mst_scl_i_o, e_si);
        chk("mst_sda_in", mst_sda_i_o, e_di);
        if (done_o) last_done_t = t;
        if (tmo_o)  last_tmo_t = t;
        if (err_o)  last_err_t = t;
        // bus is free when the IDLE cycles before this one were all quiet
        free_now = (m_lastbad < t - IDLE);
        if (mode == 0 && v) begin
            if (id >= NM) m_err_at = t + 1;
            else if (id == m_cur) m_done_at = t + 1;
            else begin m_sw = 1; m_acc = t; m_tgt = id; m_ps = -1; m_flag = 0; end
        end else if (mode == 1 && m_ps < 0) begin
            if (free_now) m_ps = t + 1;
            else if (t - (m_acc + 1) == TMO - 1) begin m_ps = t + 1; m_flag = 1; end
            if (m_ps >= 0) begin
                m_dc = m_ps + PARK;
                m_done_at = m_dc;
                if (m_flag) m_tmo_at = m_dc;
            end
        end
        st = ps_sda && !s_sda && s_scl && ps_scl;
        sp = !ps_sda && s_sda && s_scl && ps_scl;
        if (m_busy || !s_scl || !s_sda) m_lastbad = t;
        if (sp) m_busy = 0; else if (st) m_busy = 1;
        ps_scl = s_scl; ps_sda = s_sda;
        @(posedge clk_i);
        t++;
        @(negedge clk_i);
    endtask

    task automatic run_until_idle(input int maxc, input bit scl, input bit sda);
        int k = 0;
        while (m_sw && k < maxc) begin cycle(0, 0, scl, sda); k++; end
        chk("bound", sel_ready_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, p;
        bit quiet;
        dinv = DINV;
        #1 rst_i = 1'b1;
        #2;
        chk("rst_cur", sel_cur_o, RSEL);
        chk("rst_ready", sel_ready_o, 1);
        chk("rst_pulses", {done_o, tmo_o, err_o, busy_o}, 0);
        chk("rst_scl_dir", pad_scl_dir_o, 1);
        chk("rst_mst_in", {mst_scl_i_o, mst_sda_i_o}, 6'h3f);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // bus idle long enough, then switch to master 0
        repeat (20) cycle(0, 0, 1, 1);
        n = t; cycle(1, 0, 1, 1);
        run_until_idle(100, 1, 1);
        chk("sw_lat", last_done_t - n, 4);
        chk("sw_cur", sel_cur_o, 0);

        // START, request 2 while busy, STOP later: waits for idle after STOP
        cycle(0, 0, 1, 0);
        repeat (3) cycle(0, 0, $urandom_range(0, 1), 0);
        cycle(1, 2, 1, 0);
        repeat (30) cycle(0, 0, $urandom_range(0, 1), 0);
        cycle(0, 0, 1, 0);
        p = t; cycle(0, 0, 1, 1);
        run_until_idle(100, 1, 1);
        chk("stop_lat", last_done_t - p, 22);
        chk("stop_cur", sel_cur_o, 2);

        // SDA stuck low: switch forced by timeout
        repeat (5) cycle(0, 0, 1, 0);
        n = t; cycle(1, 1, 1, 0);
        run_until_idle(200, 1, 0);
        chk("tmo_lat", last_tmo_t - n, 67);
        chk("tmo_done", last_done_t - n, 67);

        // out-of-range id, then same-id request
        repeat (3) cycle(0, 0, 1, 1);
        n = t; cycle(1, 3, 1, 1); cycle(0, 0, 1, 1);
        chk("err_lat", last_err_t - n, 1);
        n = t; cycle(1, 1, 1, 1); cycle(0, 0, 1, 1);
        chk("same_lat", last_done_t - n, 1);
        chk("same_cur", sel_cur_o, 1);

        // random traffic: alternating quiet and noisy pad segments
        repeat (1500) begin
            quiet = ((t / 40) % 2) == 0;
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3),
                  quiet ? 1'b1 : 1'($urandom_range(0, 1)),
                  quiet ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        // clean STOP, settle on master 0, then reset in the middle of PARK
        run_until_idle(200, 1, 1);
        cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
        repeat (20) cycle(0, 0, 1, 1);
        cycle(1, 0, 1, 1);
        run_until_idle(200, 1, 1);
        repeat (3) cycle(0, 0, 1, 1);
        cycle(1, 2, 1, 1);
        n = 0;
        while (!(m_sw && m_ps >= 0 && t >= m_ps) && n < 200) begin cycle(0, 0, 1, 1); n++; end
        chk("park_rel", {pad_scl_dir_o, pad_sda_dir_o, sel_cur_o}, 0);
        rst_i = 1'b1;
        #1;
        chk("prst_cur", sel_cur_o, RSEL);
        chk("prst_ready", sel_ready_o, 1);
        chk("prst_pad", {pad_scl_o, pad_scl_dir_o},
            {mst_scl_o_i[RSEL], mst_scl_dir_i[RSEL] ^ dinv[RSEL]});
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        repeat (30) cycle(0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_pin_arbiter.md
# i2c_pin_arbiter

Runtime-switchable arbiter that shares one I2C pad pair among `NUM_MST` I2C controllers (native and APB). It replaces the fixed two-way select register at SoC top. Switching is glitch-free: the pads are only handed over when the bus is observed free or a timeout expires, with a park interval in between. Per-master direction polarity is normalised, and non-selected masters see an idle bus.

## Interface
Parameters:
- `NUM_MST`, 2 — number of masters, 2..8; `SW = $clog2(NUM_MST)`.
- `DIR_INV`, 0 — NUM_MST-bit mask; bit k=1 means master k's `dir` is active-low (inverted before use).
- `RST_SEL`, 0 — master selected out of reset.
- `IDLE_CYC`, 16 — consecutive cycles of SCL=SDA=1 with no transaction needed to call the bus free; range 1..255.
- `PARK_CYC`, 2 — cycles with all pad drivers released before commit; range 1..15.
- `TMO_CYC`, 4096 — WAIT timeout in cycles; 0 disables the timeout.

Ports:
- `clk_i` in 1 — clock.
- `rst_i` in 1 — **asynchronous, active-high reset**.
- `sel_valid_i` in 1 — switch request valid.
- `sel_id_i` in SW — requested master.
- `sel_ready_o` out 1 — request accepted when valid&ready.
- `sel_cur_o` out SW — currently connected master.
- `done_o` out 1 — one-cycle pulse when a request completes.
- `tmo_o` out 1 — one-cycle pulse, coincident with `done_o`, when a switch was forced by timeout.
- `err_o` out 1 — one-cycle pulse when an out-of-range id is rejected.
- `busy_o` out 1 — bus-monitor busy flag (START seen, STOP not yet seen).
- `mst_scl_o_i`, `mst_scl_dir_i`, `mst_sda_o_i`, `mst_sda_dir_i` in NUM_MST — per-master pad drive and direction.
- `mst_scl_i_o`, `mst_sda_i_o` out NUM_MST — per-master pad inputs.
- `pad_scl_i`, `pad_sda_i` in 1 — raw pad inputs (asynchronous).
- `pad_scl_o`, `pad_scl_dir_o`, `pad_sda_o`, `pad_sda_dir_o` out 1 — pad drive; `dir`=1 means output enabled.

## Operation
- **Direction normalisation:** `dir_n[k] = mst_*_dir_i[k] ^ DIR_INV[k]`.
- **Pad drive:** in IDLE/WAIT, the pads take `o`/`dir_n` of `sel_cur_o`. In PARK, `pad_*_o`=1 and `pad_*_dir_o`=0.
- **Master inputs:**
  - `pad_scl_i`/`pad_sda_i` pass through a 2-flop synchroniser to give `scl_s`/`sda_s`.
  - The selected master (outside PARK) receives `scl_s`/`sda_s`.
  - All other masters, and every master during PARK, receive constant 1.
- **Bus monitor** (on `scl_s`/`sda_s` plus one delayed copy):
  - START = SDA 1→0 while SCL=1; sets `busy_o`.
  - STOP = SDA 0→1 while SCL=1; clears `busy_o`.
  - START and STOP in the same cycle cannot occur; if both decode, STOP wins.
  - `idle_cnt` increments, saturating at `IDLE_CYC`, while `!busy_o & scl_s & sda_s`; otherwise it clears to 0.
  - `bus_free = (idle_cnt == IDLE_CYC)`.
- **FSM:**
  - IDLE: `sel_ready_o`=1.
    - On valid with `sel_id_i >= NUM_MST`: pulse `err_o`, stay IDLE.
    - On valid with `sel_id_i == sel_cur_o`: pulse `done_o` next cycle, stay IDLE.
    - Otherwise: latch target, clear `tmo_cnt`, go to WAIT.
  - WAIT: `sel_ready_o`=0.
    - If `bus_free`: go to PARK.
    - Else if `TMO_CYC!=0` and `tmo_cnt==TMO_CYC-1`: set the `tmo` flag, go to PARK.
    - Else: `tmo_cnt++`.
  - PARK: `PARK_CYC` cycles. On the last cycle: `sel_cur_o <= target`, go to IDLE, `done_o` (and `tmo_o` if flagged) register high for one cycle.
- **Reset mid-switch:** the FSM returns to IDLE, `sel_cur_o=RST_SEL`, the target is discarded, and no `done_o` is issued.

## Timing
- **Reset values:** `sel_cur_o=RST_SEL`; `sel_ready_o=1`; `done_o=tmo_o=err_o=0`; `busy_o=0`; `idle_cnt=0`; synchroniser flops=1; pads follow `RST_SEL`.
- **Pad input latency:** 2 cycles from pad to `scl_s`/`sda_s`. `busy_o` asserts 1 cycle after the START decode.
- **Switch latency:**
  - Accept at cycle N.
  - WAIT at N+1; with `bus_free` already 1, PARK at N+2..N+1+PARK_CYC.
  - `sel_cur_o`, `done_o` and IDLE at N+2+PARK_CYC, which is N+4 with defaults.
  - `sel_ready_o` returns to 1 in the same cycle as `done_o`.
- **Same-id request:** `done_o` at N+1, `sel_ready_o` stays 1.
- **Out-of-range request:** `err_o` at N+1.
- **Timeout:** PARK entered at N+1+TMO_CYC.
- **Glitch-free handover:** pad outputs never change directly from master A to master B without ≥`PARK_CYC` released cycles in between.

## Test plan
- Reset with `RST_SEL=1`, `NUM_MST=3`, `DIR_INV=3'b010` → `sel_cur_o`=1. Master1 drives `scl_dir`=0, which appears as `pad_scl_dir_o`=1. Masters 0 and 2 read SCL=SDA=1.
- Lines idle for 16 cycles, request id 0 at cycle N → pads released at N+2..N+3, `sel_cur_o`=0 and `done_o` at N+4, `tmo_o`=0.
- START on the pads, request id 2, STOP 100 cycles later → FSM holds WAIT until 16 idle cycles after STOP, then PARK; `busy_o` high between START and STOP.
- `TMO_CYC=64`, SDA held low, request id 1 → PARK entered at N+65, `done_o` and `tmo_o` both pulse at N+67.
- Request id 3 with `NUM_MST=3` → `err_o` pulse, no state change. Request equal to current → `done_o` at N+1 only.
- Assert `rst_i` during PARK → `sel_cur_o`=`RST_SEL` immediately (asynchronous), no `done_o`, pads reconnected to master `RST_SEL`.
